bamse_io_responder: RTL and testbench

BAMSE_IO_RESPONDER -- requirements
Module: bamse_io_responder

---
 rtl/bamse_io_pkg.sv | 20 ++
 rtl/bamse_sync.sv | 32 +++
 rtl/bamse_io_responder.sv | 131 +++++++++++++
 tb/tb_bamse_io_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bamse_io_pkg.sv
// rtl/bamse_io_pkg.sv - shared constants for the bamse I/O responder
//   Port address map, button/switch widths and interrupt FSM state encoding.
package bamse_io_pkg;

    localparam int NUM_BTN = 3;
    localparam int NUM_SW  = 8;

    localparam logic [7:0] ADDR_PORTA    = 8'h00;
    localparam logic [7:0] ADDR_PORTB    = 8'h01;
    localparam logic [7:0] ADDR_PORTC    = 8'h02;
    localparam logic [7:0] ADDR_IRQ_PEND = 8'h03;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'h04;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/bamse_sync.sv
// rtl/bamse_sync.sv - multi-flop synchronizer for asynchronous input bits
//   clk, rst_n : clock and async active-low reset
//   async_i    : asynchronous input vector
//   sync_o     : input after STAGES flops
module bamse_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/bamse_io_responder.sv
// rtl/bamse_io_responder.sv - PicoBlaze3 I/O responder with buttons, switches, LEDs and IRQ
//   clk, rst_n          : clock, async active-low reset
//   port_id, out_port   : processor address and write data
//   write_strobe        : write qualifier; read_strobe has no side effects
//   in_port             : registered read data (1-cycle latency)
//   interrupt           : interrupt request, interrupt_ack its acknowledge
//   pbuttons, switches  : asynchronous inputs, leds : LED register
module bamse_io_responder
    import bamse_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [2:0] pbuttons,
    input  logic [7:0] switches,
    output logic [7:0] leds
);

    logic [NUM_BTN-1:0] btn_sync;
    logic [NUM_SW-1:0]  sw_sync;
    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] btn_rise;

    logic [7:0]         leds_q,    leds_d;
    logic [NUM_BTN-1:0] pend_q,    pend_d;
    logic [NUM_BTN-1:0] mask_q,    mask_d;
    logic [7:0]         in_port_q, in_port_d;
    irq_state_e         state_q,   state_d;

    logic               active;
    logic               unused_read_strobe;

    // Reads have no side effects, so the read qualifier is not needed.
    assign unused_read_strobe = read_strobe;

    bamse_sync #(.WIDTH(NUM_BTN), .STAGES(SYNC_STAGES)) u_sync_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (pbuttons),
        .sync_o  (btn_sync)
    );

    bamse_sync #(.WIDTH(NUM_SW), .STAGES(SYNC_STAGES)) u_sync_sw (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (switches),
        .sync_o  (sw_sync)
    );

    assign btn_rise = btn_sync & ~btn_prev_q;
    assign active   = |(pend_q & mask_q);

    // Register file next state; a rising edge overrides a same-cycle W1C.
    always_comb begin
        leds_d = leds_q;
        mask_d = mask_q;
        pend_d = pend_q;
        if (write_strobe) begin
            case (port_id)
                ADDR_PORTC:    leds_d = out_port;
                ADDR_IRQ_PEND: pend_d = pend_q & ~out_port[NUM_BTN-1:0];
                ADDR_IRQ_MASK: mask_d = out_port[NUM_BTN-1:0];
                default:       ;
            endcase
        end
        pend_d = pend_d | btn_rise;
    end

    // Read mux, registered every cycle from the current address.
    always_comb begin
        in_port_d = 8'h00;
        case (port_id)
            ADDR_PORTA:    in_port_d = {5'b0, btn_sync};
            ADDR_PORTB:    in_port_d = sw_sync;
            ADDR_PORTC:    in_port_d = leds_q;
            ADDR_IRQ_PEND: in_port_d = {5'b0, pend_q};
            ADDR_IRQ_MASK: in_port_d = {5'b0, mask_q};
            default:       in_port_d = 8'h00;
        endcase
    end

    // SERVICE holds until the active sources drop, so one event yields one request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE: begin
                if (active) state_d = IRQ_REQ;
            end
            IRQ_REQ: begin
                if (interrupt_ack)  state_d = IRQ_SERVICE;
                else if (!active)   state_d = IRQ_IDLE;
            end
            IRQ_SERVICE: begin
                if (!active) state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            leds_q     <= 8'h00;
            pend_q     <= '0;
            mask_q     <= '0;
            in_port_q  <= 8'h00;
            state_q    <= IRQ_IDLE;
        end else begin
            btn_prev_q <= btn_sync;
            leds_q     <= leds_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            in_port_q  <= in_port_d;
            state_q    <= state_d;
        end
    end

    // Pure decode of the state register: no path from any input.
    assign interrupt = (state_q == IRQ_REQ);
    assign in_port   = in_port_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_bamse_io_responder.sv
// tb/tb_bamse_io_responder.sv - self-checking bench for bamse_io_responder
module tb_bamse_io_responder;

    localparam int S = 2;
    localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic [2:0] pbuttons;
    logic [7:0] switches;
    logic [7:0] leds;

    int n_cmp = 0;
    int n_err = 0;

    bamse_io_responder #(.SYNC_STAGES(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .pbuttons      (pbuttons),
        .switches      (switches),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [2:0] m_bh [S];
    logic [7:0] m_sh [S];
    logic [2:0] m_prev, m_pend, m_mask;
    logic [7:0] m_leds, m_in;
    int         m_mode;

    typedef struct {
        logic [7:0] pid;
        logic       ws;
        logic [7:0] dout;
        logic [7:0] exp_in;
        logic [7:0] exp_leds;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_bh[i] = '0;
            m_sh[i] = '0;
        end
        m_prev = '0; m_pend = '0; m_mask = '0;
        m_leds = '0; m_in = '0; m_mode = M_IDLE;
    endtask

    task automatic model_edge();
        logic [2:0] bs, rise, np;
        logic [7:0] ss;
        logic       act;
        bs   = m_bh[S-1];
        ss   = m_sh[S-1];
        rise = bs & ~m_prev;
        act  = (m_pend & m_mask) != 0;
        case (port_id)
            8'h00:   m_in = {5'b0, bs};
            8'h01:   m_in = ss;
            8'h02:   m_in = m_leds;
            8'h03:   m_in = {5'b0, m_pend};
            8'h04:   m_in = {5'b0, m_mask};
            default: m_in = 8'h00;
        endcase
        np = m_pend;
        if (write_strobe && port_id == 8'h02) m_leds = out_port;
        if (write_strobe && port_id == 8'h04) m_mask = out_port[2:0];
        if (write_strobe && port_id == 8'h03) np = np & ~out_port[2:0];
        m_pend = np | rise;
        if (m_mode == M_IDLE && act) m_mode = M_REQ;
        else if (m_mode == M_REQ && interrupt_ack) m_mode = M_SVC;
        else if (m_mode == M_REQ && !act) m_mode = M_IDLE;
        else if (m_mode == M_SVC && !act) m_mode = M_IDLE;
        for (int i = S - 1; i > 0; i--) begin
            m_bh[i] = m_bh[i-1];
            m_sh[i] = m_sh[i-1];
        end
        m_bh[0] = pbuttons;
        m_sh[0] = switches;
        m_prev  = bs;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_in_port", in_port, m_in);
        check("model_leds", leds, m_leds);
        check("model_irq", {7'b0, interrupt}, {7'b0, m_mode == M_REQ});
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; out_port = d; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
        port_id = a; write_strobe = 1'b0;
        step();
        check(name, in_port, exp);
    endtask

    task automatic wait_irq(input string name);
        for (int i = 0; i < 10; i++) begin
            step();
            if (interrupt) break;
        end
        check(name, {7'b0, interrupt}, 8'h01);
    endtask

    initial begin
        vecs[0]  = '{8'h01, 1'b0, 8'h00, 8'hA5, 8'h00};
        vecs[1]  = '{8'h07, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{8'h02, 1'b1, 8'h3C, 8'h00, 8'h3C};
        vecs[3]  = '{8'h02, 1'b0, 8'h55, 8'h3C, 8'h3C};
        vecs[4]  = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'h3C};
        vecs[5]  = '{8'h04, 1'b1, 8'hFF, 8'h00, 8'h3C};
        vecs[6]  = '{8'h04, 1'b0, 8'h00, 8'h07, 8'h3C};
        vecs[7]  = '{8'h04, 1'b1, 8'h00, 8'h07, 8'h3C};
        vecs[8]  = '{8'h04, 1'b0, 8'h00, 8'h00, 8'h3C};
        vecs[9]  = '{8'h01, 1'b1, 8'h00, 8'hA5, 8'h3C};
        vecs[10] = '{8'hFF, 1'b1, 8'h12, 8'h00, 8'h3C};
        vecs[11] = '{8'h02, 1'b0, 8'h00, 8'h3C, 8'h3C};

        rst_n = 1'b0; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        out_port = 8'h00; interrupt_ack = 1'b0; pbuttons = 3'b000; switches = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_port", in_port, 8'h00);
        check("reset_leds", leds, 8'h00);
        check("reset_irq", {7'b0, interrupt}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Switch read latency
        switches = 8'hA5; port_id = 8'h01;
        for (int i = 0; i < S + 2; i++) begin
            step();
            if (in_port == 8'hA5) break;
        end
        check("portb_latency", in_port, 8'hA5);
        expect_reg("unmapped_read", 8'h07, 8'h00);

        // Register map vectors
        for (int i = 0; i < 12; i++) begin
            port_id = vecs[i].pid; write_strobe = vecs[i].ws; out_port = vecs[i].dout;
            step();
            check($sformatf("vec%0d_in_port", i), in_port, vecs[i].exp_in);
            check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
            check($sformatf("vec%0d_irq", i), {7'b0, interrupt}, 8'h00);
        end
        write_strobe = 1'b0;

        // Masked-in button 0: request, ack, service, W1C, re-request
        wr(8'h04, 8'h01);
        pbuttons = 3'b001;
        wait_irq("irq_assert");
        pbuttons = 3'b000;
        repeat (3) step();
        check("irq_held_until_ack", {7'b0, interrupt}, 8'h01);
        expect_reg("pend_btn0", 8'h03, 8'h01);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        check("irq_after_ack", {7'b0, interrupt}, 8'h00);
        repeat (4) step();
        check("irq_service_hold", {7'b0, interrupt}, 8'h00);
        wr(8'h03, 8'h01);
        expect_reg("pend_cleared", 8'h03, 8'h00);
        check("irq_after_clear", {7'b0, interrupt}, 8'h00);
        pbuttons = 3'b001;
        wait_irq("irq_reassert");
        pbuttons = 3'b000;
        interrupt_ack = 1'b1; step(); interrupt_ack = 1'b0;
        wr(8'h03, 8'h07);
        repeat (3) step();

        // Masked-out button 1, then unmask
        wr(8'h04, 8'h00);
        pbuttons = 3'b010;
        for (int i = 0; i < 6; i++) begin
            step();
            check("irq_masked", {7'b0, interrupt}, 8'h00);
        end
        pbuttons = 3'b000;
        expect_reg("pend_btn1", 8'h03, 8'h02);
        wr(8'h04, 8'h02);
        step();
        check("irq_unmask", {7'b0, interrupt}, 8'h01);
        interrupt_ack = 1'b1; step(); interrupt_ack = 1'b0;
        wr(8'h03, 8'h07);
        repeat (3) step();

        // Rising edge of button 2 coincides with a W1C of bit 2
        wr(8'h04, 8'h04);
        pbuttons = 3'b100;
        repeat (S) step();
        wr(8'h03, 8'h04);
        expect_reg("pend_set_wins", 8'h03, 8'h04);
        wr(8'h02, 8'h5A);
        step();
        check("irq_before_reset", {7'b0, interrupt}, 8'h01);

        // Async reset mid-REQ with button 2 held through it
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_irq", {7'b0, interrupt}, 8'h00);
        check("async_rst_leds", leds, 8'h00);
        check("async_rst_in_port", in_port, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_reg("mask_after_rst", 8'h04, 8'h00);
        repeat (S + 3) step();
        expect_reg("held_btn_one_set", 8'h03, 8'h04);
        wr(8'h03, 8'h04);
        repeat (4) step();
        expect_reg("held_btn_no_reset", 8'h03, 8'h00);
        pbuttons = 3'b000;

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            port_id       = ($urandom_range(0, 15) == 0) ? 8'(($urandom_range(0, 255))) : 8'($urandom_range(0, 5));
            write_strobe  = ($urandom_range(0, 3) == 0);
            out_port      = 8'($urandom_range(0, 255));
            interrupt_ack = ($urandom_range(0, 3) == 0);
            read_strobe   = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) pbuttons = pbuttons ^ (3'b001 << $urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) switches = 8'($urandom_range(0, 255));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
